inst_fetch_ctrl: RTL and testbench



---
 rtl/cpu_pkg.sv | 19 +
 rtl/inst_fetch_ctrl_if.sv | 24 ++
 rtl/inst_fetch_ctrl_prog_range_chk.sv | 22 ++
 rtl/inst_fetch_ctrl.sv | 111 +++++++++++
 tb/tb_inst_fetch_ctrl.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU constants and fetch-stage types. The program-memory decoder
// imports the same window so both ends of the bus agree on legal addresses.
package cpu_pkg;

  localparam int unsigned INSTR_W   = 32;
  localparam logic [31:0] RESET_PC   = 32'h0000_0240;
  localparam logic [31:0] PROG_BASE  = 32'h0000_0240;
  localparam logic [31:0] PROG_LIMIT = 32'h0000_123F;

  // FS_START is the fetch-pending state held during and just after reset
  typedef enum logic [2:0] {
    FS_START,
    FS_FETCH,
    FS_VALID,
    FS_DRAIN,
    FS_FAULT
  } fetch_state_e;

endpackage

// File: rtl/inst_fetch_ctrl_if.sv
// Program-memory read bus plus the fetch-to-decode instruction handshake.
interface inst_fetch_ctrl_if;
  import cpu_pkg::*;

  logic               mem_req;
  logic [31:0]        mem_addr;
  logic               mem_ack;
  logic [INSTR_W-1:0] mem_rdata;
  logic               inst_valid;
  logic               inst_ready;
  logic [INSTR_W-1:0] inst_data;
  logic [31:0]        inst_pc;

  modport master (
    output mem_req, mem_addr, inst_valid, inst_data, inst_pc,
    input  mem_ack, mem_rdata, inst_ready
  );

  modport slave (
    input  mem_req, mem_addr, inst_valid, inst_data, inst_pc,
    output mem_ack, mem_rdata, inst_ready
  );

endinterface

// File: rtl/inst_fetch_ctrl_prog_range_chk.sv
// Combinational program-window check: word aligned and all four bytes inside
// [BASE, LIMIT]. Arithmetic is 33 bits wide so addr+3 cannot wrap into range.
module prog_range_chk
  import cpu_pkg::*;
#(
  parameter logic [31:0] BASE  = PROG_BASE,
  parameter logic [31:0] LIMIT = PROG_LIMIT
) (
  input  logic [31:0] addr_i,
  output logic        in_range_o
);

  logic [32:0] firstByte;
  logic [32:0] lastByte;

  assign firstByte  = {1'b0, addr_i};
  assign lastByte   = firstByte + 33'd3;
  assign in_range_o = (firstByte >= {1'b0, BASE}) &&
                      (lastByte <= {1'b0, LIMIT}) &&
                      (addr_i[1:0] == 2'b00);

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch initiator: owns the PC, issues one program-memory read per
// instruction, hands results to decode and raises a sticky fault on bad PCs.
module inst_fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = cpu_pkg::RESET_PC,
  parameter logic [31:0] PROG_BASE  = cpu_pkg::PROG_BASE,
  parameter logic [31:0] PROG_LIMIT = cpu_pkg::PROG_LIMIT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                redirect_valid,
  input  logic [31:0]         redirect_pc,
  inst_fetch_ctrl_if.master   bus,
  output logic                fetch_fault,
  output logic [31:0]         fault_pc
);
  import cpu_pkg::*;

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  req_addr_q, req_addr_d;
  logic [31:0]  inst_data_q, inst_data_d;
  logic [31:0]  inst_pc_q, inst_pc_d;
  logic [31:0]  fault_pc_q, fault_pc_d;

  logic [31:0]  entryAddr;
  logic         entryOk;
  logic         enterFetch;

  // Every entry into FETCH targets either the redirect address or the current PC
  assign entryAddr = redirect_valid ? redirect_pc : pc_q;

  prog_range_chk #(
    .BASE  (PROG_BASE),
    .LIMIT (PROG_LIMIT)
  ) u_range_chk (
    .addr_i     (entryAddr),
    .in_range_o (entryOk)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FS_START;
      pc_q        <= RESET_PC;
      req_addr_q  <= RESET_PC;
      inst_data_q <= '0;
      inst_pc_q   <= '0;
      fault_pc_q  <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_addr_q  <= req_addr_d;
      inst_data_q <= inst_data_d;
      inst_pc_q   <= inst_pc_d;
      fault_pc_q  <= fault_pc_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    req_addr_d  = req_addr_q;
    inst_data_d = inst_data_q;
    inst_pc_d   = inst_pc_q;
    fault_pc_d  = fault_pc_q;
    enterFetch  = 1'b0;

    if (redirect_valid) pc_d = redirect_pc;

    unique case (state_q)
      FS_START: enterFetch = 1'b1;
      FS_FETCH: begin
        if (bus.mem_ack) begin
          if (redirect_valid) begin
            enterFetch = 1'b1;
          end else begin
            inst_data_d = bus.mem_rdata;
            inst_pc_d   = req_addr_q;
            pc_d        = pc_q + 32'd4;
            state_d     = FS_VALID;
          end
        end else if (redirect_valid) begin
          // The bus request cannot be withdrawn, so finish it and drop the data
          state_d = FS_DRAIN;
        end
      end
      FS_VALID: if (redirect_valid || bus.inst_ready) enterFetch = 1'b1;
      FS_DRAIN: if (bus.mem_ack) enterFetch = 1'b1;
      FS_FAULT: if (redirect_valid) enterFetch = 1'b1;
      default:  state_d = FS_START;
    endcase

    if (enterFetch) begin
      if (entryOk) begin
        state_d    = FS_FETCH;
        req_addr_d = entryAddr;
      end else begin
        state_d    = FS_FAULT;
        fault_pc_d = entryAddr;
      end
    end
  end

  assign bus.mem_req    = (state_q == FS_FETCH) || (state_q == FS_DRAIN);
  assign bus.mem_addr   = req_addr_q;
  assign bus.inst_valid = (state_q == FS_VALID);
  assign bus.inst_data  = inst_data_q;
  assign bus.inst_pc    = inst_pc_q;
  assign fetch_fault    = (state_q == FS_FAULT);
  assign fault_pc       = fault_pc_q;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Self-checking bench for inst_fetch_ctrl: a program-memory model with settable
// ack latency feeds a scoreboard that is checked against the decode-side output.
module tb_inst_fetch_ctrl;
  import cpu_pkg::*;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        fetch_fault;
  logic [31:0] fault_pc;

  int          vectorsApplied = 0;
  int          miscompares = 0;

  exp_t        sbQ[$];
  logic [31:0] reqLog[$];
  exp_t        curExp = '0;
  int          memLatency = 0;
  int          waitCnt = 0;
  int          instCount = 0;
  bit          txnRedir = 1'b0;
  bit          reqPrev = 1'b0;
  bit          validPrev = 1'b0;
  bit          memAck = 1'b0;
  bit          newReq = 1'b0;
  logic [31:0] txnAddr = '0;

  inst_fetch_ctrl_if bus ();

  inst_fetch_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .bus            (bus),
    .fetch_fault    (fetch_fault),
    .fault_pc       (fault_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] reqAt(input int idx);
    if (idx < reqLog.size()) return reqLog[idx];
    return 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] lastReq();
    if (reqLog.size() == 0) return 32'hFFFF_FFFF;
    return reqLog[reqLog.size()-1];
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectorsApplied++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One-cycle redirect pulse, called and returning 1 time unit after a rising edge
  task automatic applyStimulus(input logic [31:0] target);
    redirect_pc    = target;
    redirect_valid = 1'b1;
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
  endtask

  task automatic waitFault(input string tag, input int limit);
    int n = 0;
    while (!fetch_fault && n < limit) begin
      waitCycles(1);
      n++;
    end
    checkOutput(tag, {31'd0, fetch_fault}, 32'd1);
  endtask

  task automatic waitReqs(input string tag, input int count, input int limit);
    int n = 0;
    while (reqLog.size() < count && n < limit) begin
      waitCycles(1);
      n++;
    end
    checkOutput(tag, {31'd0, reqLog.size() >= count}, 32'd1);
  endtask

  task automatic waitInst(input string tag, input int count, input int limit);
    int n = 0;
    while (instCount < count && n < limit) begin
      waitCycles(1);
      n++;
    end
    checkOutput(tag, {31'd0, instCount >= count}, 32'd1);
  endtask

  task automatic waitValid(input string tag, input int limit);
    int n = 0;
    while (!bus.inst_valid && n < limit) begin
      waitCycles(1);
      n++;
    end
    checkOutput(tag, {31'd0, bus.inst_valid}, 32'd1);
  endtask

  // Memory model and decode-side monitor, evaluated mid-cycle away from the clock edge
  always @(negedge clk) begin
    if (rst) begin
      memAck      = 1'b0;
      waitCnt     = 0;
      txnRedir    = 1'b0;
      reqPrev     = 1'b0;
      validPrev   = 1'b0;
      sbQ.delete();
      bus.mem_ack = 1'b0;
    end else begin
      if (bus.inst_valid && !validPrev) begin
        instCount++;
        checkOutput("sb_depth", sbQ.size(), 32'd1);
        if (sbQ.size() != 0) curExp = sbQ.pop_front();
        checkOutput("inst_pc", bus.inst_pc, curExp.pc);
        checkOutput("inst_data", bus.inst_data, curExp.data);
      end else if (bus.inst_valid) begin
        checkOutput("inst_hold", bus.inst_data, curExp.data);
      end
      validPrev = bus.inst_valid;

      newReq = bus.mem_req && (!reqPrev || memAck);
      if (newReq) begin
        reqLog.push_back(bus.mem_addr);
        txnAddr  = bus.mem_addr;
        waitCnt  = 0;
        txnRedir = 1'b0;
      end else if (bus.mem_req) begin
        checkOutput("addr_stable", bus.mem_addr, txnAddr);
      end
      reqPrev = bus.mem_req;

      memAck = 1'b0;
      if (bus.mem_req) begin
        if (redirect_valid) txnRedir = 1'b1;
        if (waitCnt == memLatency) begin
          memAck = 1'b1;
          if (!txnRedir) sbQ.push_back('{pc: txnAddr, data: memWord(txnAddr)});
        end else begin
          waitCnt++;
        end
      end
      bus.mem_ack   = memAck;
      bus.mem_rdata = memAck ? memWord(txnAddr) : 32'hDEAD_BEEF;
    end
  end

  initial begin
    int base;
    int logSize;

    bus.mem_ack    = 1'b0;
    bus.mem_rdata  = '0;
    bus.inst_ready = 1'b0;

    // Reset values
    waitCycles(3);
    checkOutput("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
    checkOutput("rst_inst_valid", {31'd0, bus.inst_valid}, 32'd0);
    checkOutput("rst_fetch_fault", {31'd0, fetch_fault}, 32'd0);
    checkOutput("rst_inst_data", bus.inst_data, 32'd0);
    checkOutput("rst_inst_pc", bus.inst_pc, 32'd0);
    checkOutput("rst_fault_pc", fault_pc, 32'd0);

    // Zero-wait streaming from the reset PC
    rst            = 1'b0;
    bus.inst_ready = 1'b1;
    memLatency     = 0;
    waitReqs("seq_timeout", 3, 20);
    checkOutput("seq_addr0", reqAt(0), 32'h240);
    checkOutput("seq_addr1", reqAt(1), 32'h244);
    checkOutput("seq_addr2", reqAt(2), 32'h248);
    checkOutput("seq_no_fault", {31'd0, fetch_fault}, 32'd0);

    // Top of the program window
    applyStimulus(32'h1230);
    waitFault("top_fault_timeout", 60);
    checkOutput("top_fault_pc", fault_pc, 32'h1240);
    checkOutput("top_last_req", lastReq(), 32'h123C);
    waitCycles(4);
    checkOutput("top_req_held_low", {31'd0, bus.mem_req}, 32'd0);
    checkOutput("top_fault_sticky", {31'd0, fetch_fault}, 32'd1);

    // Bad redirect targets keep the fault, a good one clears it
    applyStimulus(32'h230);
    waitCycles(2);
    checkOutput("below_fault", {31'd0, fetch_fault}, 32'd1);
    checkOutput("below_fault_pc", fault_pc, 32'h230);
    checkOutput("below_no_req", {31'd0, bus.mem_req}, 32'd0);
    applyStimulus(32'h242);
    waitCycles(2);
    checkOutput("misalign_fault", {31'd0, fetch_fault}, 32'd1);
    checkOutput("misalign_fault_pc", fault_pc, 32'h242);
    reqLog.delete();
    applyStimulus(32'h400);
    waitCycles(2);
    checkOutput("resume_fault_clear", {31'd0, fetch_fault}, 32'd0);
    checkOutput("resume_addr", reqAt(0), 32'h400);

    // Redirect while a slow read is outstanding
    applyStimulus(32'h0);
    waitCycles(2);
    memLatency = 3;
    reqLog.delete();
    base = instCount;
    applyStimulus(32'h600);
    waitCycles(2);
    applyStimulus(32'h800);
    waitCycles(3);
    checkOutput("drain_no_inst", instCount - base, 32'd0);
    waitInst("drain_inst_timeout", base + 1, 30);
    checkOutput("drain_addr_old", reqAt(0), 32'h600);
    checkOutput("drain_addr_new", reqAt(1), 32'h800);

    // Decode stall, then redirect together with inst_ready
    bus.inst_ready = 1'b0;
    memLatency     = 0;
    applyStimulus(32'h0);
    waitCycles(2);
    applyStimulus(32'hA00);
    waitValid("stall_valid_timeout", 10);
    logSize = reqLog.size();
    repeat (5) begin
      waitCycles(1);
      checkOutput("stall_valid", {31'd0, bus.inst_valid}, 32'd1);
      checkOutput("stall_no_req", {31'd0, bus.mem_req}, 32'd0);
    end
    checkOutput("stall_req_count", reqLog.size(), logSize);
    bus.inst_ready = 1'b1;
    applyStimulus(32'hC00);
    waitReqs("redir_ready_timeout", logSize + 1, 10);
    checkOutput("redir_wins_addr", reqAt(logSize), 32'hC00);

    // Reset during a pending read
    applyStimulus(32'h0);
    waitCycles(2);
    memLatency = 3;
    applyStimulus(32'h700);
    waitCycles(1);
    rst = 1'b1;
    waitCycles(1);
    checkOutput("rstwait_mem_req", {31'd0, bus.mem_req}, 32'd0);
    checkOutput("rstwait_inst_valid", {31'd0, bus.inst_valid}, 32'd0);
    checkOutput("rstwait_fault_pc", fault_pc, 32'd0);
    waitCycles(1);
    rst        = 1'b0;
    memLatency = 0;
    reqLog.delete();
    waitReqs("rstwait_req_timeout", 1, 10);
    checkOutput("rstwait_first_addr", reqAt(0), 32'h240);

    // Reset while an instruction is waiting for decode
    bus.inst_ready = 1'b0;
    waitValid("rstvalid_timeout", 10);
    rst = 1'b1;
    waitCycles(1);
    checkOutput("rstvalid_inst_valid", {31'd0, bus.inst_valid}, 32'd0);
    checkOutput("rstvalid_mem_req", {31'd0, bus.mem_req}, 32'd0);
    checkOutput("rstvalid_inst_data", bus.inst_data, 32'd0);
    checkOutput("rstvalid_inst_pc", bus.inst_pc, 32'd0);
    waitCycles(1);
    rst = 1'b0;
    reqLog.delete();
    bus.inst_ready = 1'b1;
    waitReqs("rstvalid_req_timeout", 1, 10);
    checkOutput("rstvalid_first_addr", reqAt(0), 32'h240);

    waitCycles(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end

endmodule
